// File: rtl/msad_mv_select.sv
// Block-level motion-vector selector: folds per-batch SAD minima into one
// block minimum and reports it as a signed (mv_x, mv_y) displacement.
module msad_mv_select #(
   parameter int SAD_BIT_WIDTH     = 14,
   parameter int BATCHES_PER_BLOCK = 16,
   parameter int INDEX_WIDTH       = 4,
   parameter int MV_BIT_WIDTH      = 5,
   parameter int SEARCH_OFFSET     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     start_i,
   input  logic                     interim_valid_i,
   input  logic [SAD_BIT_WIDTH-1:0] MSAD_interim_i,
   input  logic [INDEX_WIDTH-1:0]   MSAD_index_interim_i,
   input  logic                     res_ready_i,
   output logic                     res_valid_o,
   output logic [SAD_BIT_WIDTH-1:0] best_sad_o,
   output logic [MV_BIT_WIDTH-1:0]  mv_x_o,
   output logic [MV_BIT_WIDTH-1:0]  mv_y_o,
   output logic                     busy_o
);

   localparam int BW =
      (BATCHES_PER_BLOCK > 1) ? $clog2(BATCHES_PER_BLOCK) : 1;
   localparam logic [BW-1:0] LAST = BW'(BATCHES_PER_BLOCK - 1);
   localparam logic [MV_BIT_WIDTH-1:0] OFS =
      MV_BIT_WIDTH'(SEARCH_OFFSET);

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      HOLD
   } state_e;

   state_e                   state_q, state_d;
   logic [BW-1:0]            batch_q, batch_d;
   logic [SAD_BIT_WIDTH-1:0] best_sad_q, best_sad_d;
   logic [INDEX_WIDTH-1:0]   best_idx_q, best_idx_d;
   logic [BW-1:0]            best_batch_q, best_batch_d;
   logic                     accept;
   logic                     take;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         batch_q      <= '0;
         best_sad_q   <= '0;
         best_idx_q   <= '0;
         best_batch_q <= '0;
      end else begin
         state_q      <= state_d;
         batch_q      <= batch_d;
         best_sad_q   <= best_sad_d;
         best_idx_q   <= best_idx_d;
         best_batch_q <= best_batch_d;
      end
   end

   // Batch 0 seeds the minimum; later batches win only when strictly smaller.
   always_comb begin
      state_d      = state_q;
      batch_d      = batch_q;
      best_sad_d   = best_sad_q;
      best_idx_d   = best_idx_q;
      best_batch_d = best_batch_q;
      accept       = (state_q == SEARCH) && interim_valid_i;
      take         = accept &&
                     ((batch_q == '0) || (MSAD_interim_i < best_sad_q));

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SEARCH;
               batch_d = '0;
            end
         end
         SEARCH: begin
            if (accept) begin
               if (batch_q == LAST) begin
                  state_d = HOLD;
               end else begin
                  batch_d = batch_q + BW'(1);
               end
            end
         end
         HOLD: begin
            if (res_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (take) begin
         best_sad_d   = MSAD_interim_i;
         best_idx_d   = MSAD_index_interim_i;
         best_batch_d = batch_q;
      end
   end

   assign res_valid_o = (state_q == HOLD);
   assign busy_o      = (state_q != IDLE);
   assign best_sad_o  = best_sad_q;
   assign mv_x_o      = MV_BIT_WIDTH'(best_idx_q) - OFS;
   assign mv_y_o      = MV_BIT_WIDTH'(best_batch_q) - OFS;

endmodule

// File: tb/tb_msad_mv_select.sv
// Bench for msad_mv_select: directed block searches plus random blocks
// checked against a first-minimum reference model.
module tb_msad_mv_select;

   localparam int SW  = 14;
   localparam int NB  = 16;
   localparam int IW  = 4;
   localparam int MW  = 5;
   localparam int OFS = 8;

   typedef logic [SW-1:0] sad_a_t [NB];
   typedef logic [IW-1:0] idx_a_t [NB];

   logic          clk = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          start_i = 1'b0;
   logic          interim_valid_i = 1'b0;
   logic [SW-1:0] MSAD_interim_i = '0;
   logic [IW-1:0] MSAD_index_interim_i = '0;
   logic          res_ready_i = 1'b0;
   logic          res_valid_o;
   logic [SW-1:0] best_sad_o;
   logic [MW-1:0] mv_x_o;
   logic [MW-1:0] mv_y_o;
   logic          busy_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   msad_mv_select dut (
      .clk_i                (clk),
      .rst_n_i              (rst_n_i),
      .start_i              (start_i),
      .interim_valid_i      (interim_valid_i),
      .MSAD_interim_i       (MSAD_interim_i),
      .MSAD_index_interim_i (MSAD_index_interim_i),
      .res_ready_i          (res_ready_i),
      .res_valid_o          (res_valid_o),
      .best_sad_o           (best_sad_o),
      .mv_x_o               (mv_x_o),
      .mv_y_o               (mv_y_o),
      .busy_o               (busy_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: first (lowest batch) occurrence of the smallest SAD.
   function automatic void model(input sad_a_t s, input idx_a_t ix,
                                 output logic [SW-1:0] es,
                                 output logic [MW-1:0] ex,
                                 output logic [MW-1:0] ey);
      int bb;
      bb = 0;
      for (int b = 1; b < NB; b++)
         if (s[b] < s[bb]) bb = b;
      es = s[bb];
      ex = MW'(int'(ix[bb]) - OFS);
      ey = MW'(bb - OFS);
   endfunction

   // mode 0: back-to-back, 1: stall before every batch, 2: random stalls
   task automatic run_block(input sad_a_t s, input idx_a_t ix,
                            input bit do_start, input int mode,
                            output bit early, output bit t1,
                            output bit busy_ok);
      early   = 1'b0;
      busy_ok = 1'b1;
      if (do_start) begin
         start_i = 1'b1;
         step();
         start_i = 1'b0;
      end
      for (int b = 0; b < NB; b++) begin
         if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) begin
            interim_valid_i      = 1'b0;
            MSAD_interim_i       = '0;
            MSAD_index_interim_i = IW'($urandom);
            step();
            if (res_valid_o) early = 1'b1;
            if (!busy_o) busy_ok = 1'b0;
         end
         interim_valid_i      = 1'b1;
         MSAD_interim_i       = s[b];
         MSAD_index_interim_i = ix[b];
         step();
         if (b < NB - 1 && res_valid_o) early = 1'b1;
         if (!busy_o) busy_ok = 1'b0;
      end
      interim_valid_i = 1'b0;
      t1 = res_valid_o;
   endtask

   task automatic accept_result();
      res_ready_i = 1'b1;
      step();
      res_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) step();
      n_cmp++;
      if ({res_valid_o, busy_o, best_sad_o, mv_x_o, mv_y_o} !==
          {1'b0, 1'b0, 14'd0, 5'b11000, 5'b11000}) begin
         n_err++;
         $display("FAIL reset_state: got v=%b b=%b sad=%0d x=%b y=%b want 0 0 0 11000 11000",
                  res_valid_o, busy_o, best_sad_o, mv_x_o, mv_y_o);
      end
      rst_n_i = 1'b1;
      interim_valid_i = 1'b1;
      repeat (3) step();
      interim_valid_i = 1'b0;
      n_cmp++;
      if ({res_valid_o, busy_o} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_release_idle: got v=%b b=%b want 0 0",
                  res_valid_o, busy_o);
      end
   endtask

   task automatic test_monotonic();
      sad_a_t s;
      idx_a_t ix;
      bit e, t1, bk;
      for (int b = 0; b < NB; b++) begin
         s[b]  = SW'(1000 - 10 * b);
         ix[b] = IW'(b % 16);
      end
      run_block(s, ix, 1'b1, 0, e, t1, bk);
      n_cmp++;
      if ({e, t1} !== 2'b01) begin
         n_err++;
         $display("FAIL mono_latency: got early=%b valid_t1=%b want 0 1", e, t1);
      end
      n_cmp++;
      if ({best_sad_o, mv_x_o, mv_y_o} !== {14'd850, 5'd7, 5'd7}) begin
         n_err++;
         $display("FAIL mono_result: got sad=%0d x=%0d y=%0d want 850 7 7",
                  best_sad_o, $signed(mv_x_o), $signed(mv_y_o));
      end
      accept_result();
      n_cmp++;
      if ({res_valid_o, busy_o} !== 2'b00) begin
         n_err++;
         $display("FAIL mono_accept: got v=%b b=%b want 0 0", res_valid_o, busy_o);
      end
   endtask

   task automatic test_tie();
      sad_a_t s;
      idx_a_t ix;
      bit e, t1, bk;
      for (int b = 0; b < NB; b++) begin
         s[b]  = SW'(500);
         ix[b] = IW'($urandom);
      end
      s[3] = SW'(200);
      ix[3] = IW'(5);
      s[9] = SW'(200);
      ix[9] = IW'(12);
      run_block(s, ix, 1'b1, 0, e, t1, bk);
      n_cmp++;
      if ({t1, best_sad_o, mv_x_o, mv_y_o} !==
          {1'b1, 14'd200, 5'b11101, 5'b11011}) begin
         n_err++;
         $display("FAIL tie_kept: got v=%b sad=%0d x=%0d y=%0d want 1 200 -3 -5",
                  t1, best_sad_o, $signed(mv_x_o), $signed(mv_y_o));
      end
      accept_result();
   endtask

   task automatic test_stalls();
      sad_a_t s;
      idx_a_t ix;
      bit e, t1, bk;
      for (int b = 0; b < NB; b++) begin
         s[b]  = SW'(1000 - 10 * b);
         ix[b] = IW'(b % 16);
      end
      run_block(s, ix, 1'b1, 1, e, t1, bk);
      n_cmp++;
      if ({e, t1, bk} !== 3'b011) begin
         n_err++;
         $display("FAIL stall_flow: got early=%b valid_t1=%b busy_ok=%b want 0 1 1",
                  e, t1, bk);
      end
      n_cmp++;
      if ({best_sad_o, mv_x_o, mv_y_o} !== {14'd850, 5'd7, 5'd7}) begin
         n_err++;
         $display("FAIL stall_result: got sad=%0d x=%0d y=%0d want 850 7 7",
                  best_sad_o, $signed(mv_x_o), $signed(mv_y_o));
      end
      accept_result();
   endtask

   task automatic test_backpressure();
      sad_a_t s;
      idx_a_t ix;
      bit e, t1, bk;
      int bad;
      for (int b = 0; b < NB; b++) begin
         s[b]  = SW'(1000 - 10 * b);
         ix[b] = IW'(b % 16);
      end
      run_block(s, ix, 1'b1, 0, e, t1, bk);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         start_i = (c == 4);
         step();
         if ({res_valid_o, best_sad_o, mv_x_o, mv_y_o} !==
             {1'b1, 14'd850, 5'd7, 5'd7}) bad++;
      end
      start_i = 1'b0;
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
      end
      start_i = 1'b1;
      accept_result();
      start_i = 1'b0;
      n_cmp++;
      if ({res_valid_o, busy_o} !== 2'b00) begin
         n_err++;
         $display("FAIL bp_accept: got v=%b b=%b want 0 0", res_valid_o, busy_o);
      end
      step();
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL bp_accept_start_ignored: got busy=%b want 0", busy_o);
      end
   endtask

   task automatic test_reset_mid();
      sad_a_t s;
      idx_a_t ix;
      bit e, t1, bk;
      logic [SW-1:0] es;
      logic [MW-1:0] ex, ey;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int b = 0; b < 8; b++) begin
         interim_valid_i      = 1'b1;
         MSAD_interim_i       = SW'(5);
         MSAD_index_interim_i = IW'(b);
         step();
      end
      interim_valid_i = 1'b0;
      rst_n_i = 1'b0;
      #2;
      n_cmp++;
      if ({res_valid_o, busy_o, best_sad_o, mv_x_o, mv_y_o} !==
          {1'b0, 1'b0, 14'd0, 5'b11000, 5'b11000}) begin
         n_err++;
         $display("FAIL midrst_state: got v=%b b=%b sad=%0d x=%b y=%b want 0 0 0 11000 11000",
                  res_valid_o, busy_o, best_sad_o, mv_x_o, mv_y_o);
      end
      step();
      rst_n_i = 1'b1;
      interim_valid_i = 1'b1;
      repeat (4) step();
      interim_valid_i = 1'b0;
      n_cmp++;
      if ({res_valid_o, busy_o} !== 2'b00) begin
         n_err++;
         $display("FAIL midrst_no_result: got v=%b b=%b want 0 0",
                  res_valid_o, busy_o);
      end
      for (int b = 0; b < NB; b++) begin
         s[b]  = SW'($urandom_range(100, 3000));
         ix[b] = IW'($urandom);
      end
      model(s, ix, es, ex, ey);
      run_block(s, ix, 1'b1, 0, e, t1, bk);
      n_cmp++;
      if ({t1, best_sad_o, mv_x_o, mv_y_o} !== {1'b1, es, ex, ey}) begin
         n_err++;
         $display("FAIL midrst_fresh: got v=%b sad=%0d x=%0d y=%0d want 1 %0d %0d %0d",
                  t1, best_sad_o, $signed(mv_x_o), $signed(mv_y_o),
                  es, $signed(ex), $signed(ey));
      end
      accept_result();
   endtask

   task automatic test_start_coincident();
      sad_a_t s;
      idx_a_t ix;
      bit e, t1, bk;
      logic [MW-1:0] ex;
      start_i              = 1'b1;
      interim_valid_i      = 1'b1;
      MSAD_interim_i       = '0;
      MSAD_index_interim_i = IW'($urandom);
      step();
      start_i         = 1'b0;
      interim_valid_i = 1'b0;
      for (int b = 0; b < NB; b++) begin
         s[b]  = SW'(300);
         ix[b] = IW'($urandom);
      end
      ex = MW'(int'(ix[0]) - OFS);
      run_block(s, ix, 1'b0, 0, e, t1, bk);
      n_cmp++;
      if ({e, t1, best_sad_o, mv_x_o, mv_y_o} !==
          {1'b0, 1'b1, 14'd300, ex, 5'b11000}) begin
         n_err++;
         $display("FAIL coincident: got early=%b v=%b sad=%0d x=%0d y=%0d want 0 1 300 %0d -8",
                  e, t1, best_sad_o, $signed(mv_x_o), $signed(mv_y_o), $signed(ex));
      end
      accept_result();
   endtask

   task automatic test_back_to_back();
      sad_a_t s;
      idx_a_t ix;
      bit e, t1, bk;
      logic [SW-1:0] es;
      logic [MW-1:0] ex, ey;
      int bad;
      for (int k = 0; k < 8; k++) begin
         for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 3) == 0) s[b] = SW'($urandom);
            else s[b] = SW'($urandom_range(0, 15)) | (SW'(k & 1) << (SW - 1));
            ix[b] = IW'($urandom);
         end
         model(s, ix, es, ex, ey);
         run_block(s, ix, 1'b1, 2, e, t1, bk);
         n_cmp++;
         if ({e, t1, bk, best_sad_o, mv_x_o, mv_y_o} !==
             {3'b011, es, ex, ey}) begin
            n_err++;
            $display("FAIL rand_blk%0d: got e=%b v=%b bk=%b sad=%0d x=%0d y=%0d want 0 1 1 %0d %0d %0d",
                     k, e, t1, bk, best_sad_o, $signed(mv_x_o),
                     $signed(mv_y_o), es, $signed(ex), $signed(ey));
         end
         bad = 0;
         repeat ($urandom_range(0, 4)) begin
            step();
            if ({res_valid_o, best_sad_o, mv_x_o, mv_y_o} !==
                {1'b1, es, ex, ey}) bad++;
         end
         accept_result();
         n_cmp++;
         if (bad != 0 || res_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rand_hold%0d: got unstable=%0d v=%b want 0 0",
                     k, bad, res_valid_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_monotonic();
      test_tie();
      test_stalls();
      test_backpressure();
      test_reset_mid();
      test_start_coincident();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
